// File: rtl/enc_pkg.sv
// Shared constants and state type for the 8-to-3 registered priority event encoder.
package enc_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE,
        PRESENT
    } state_e;

endpackage

// File: rtl/prio_enc8.sv
// Combinational lowest-set-bit priority encoder: bit 0 has the highest priority.
module prio_enc8
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set bit is the last to overwrite idx_o.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_encoder_8to3.sv
// Registered 8-to-3 priority event encoder with rising-edge capture and valid/ack handshake.
// Optional feature: define ENC_MASK_EN to add the per-line eligibility mask port.
module irq_encoder_8to3
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
`ifdef ENC_MASK_EN
    input  logic [N_REQ-1:0] mask,
`endif
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] pending,
    output logic             ovf
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] req_q, req_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             ovf_q, ovf_d;

    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] elig;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    // Only eligible pending lines compete for presentation; masked lines still capture.
`ifdef ENC_MASK_EN
    assign elig = pending_q & ~mask;
`else
    assign elig = pending_q;
`endif

    prio_enc8 u_prio_enc8 (
        .vec_i (elig),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    // Edge capture, acknowledge clear and overflow detection; a new rise beats a clear.
    always_comb begin
        req_d = req;
        rise  = req & ~req_q;
        clr   = '0;
        if (state_q == PRESENT && ack) begin
            clr[idx_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | rise;
        ovf_d     = |(rise & pending_q & ~clr);
    end

    // Handshake FSM: idx is latched on entry to PRESENT and held until acknowledged.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (en && enc_any) begin
                    idx_d   = enc_idx;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything immediately, including a handshake in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            req_q     <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign valid   = (state_q == PRESENT);
    assign idx     = idx_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Scoreboard bench for irq_encoder_8to3: a per-line behavioural model predicts each
// post-edge output set, pushes it to a queue, and a negedge monitor pops and compares.
module tb_irq_encoder_8to3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [7:0] mask_r;
    logic       valid;
    logic [2:0] idx;
    logic [7:0] pending;
    logic       ovf;

    irq_encoder_8to3 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .ack     (ack),
`ifdef ENC_MASK_EN
        .mask    (mask_r),
`endif
        .valid   (valid),
        .idx     (idx),
        .pending (pending),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [2:0] i;
        logic [7:0] p;
        logic       o;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: per-line pending flags, previous request levels, presenting slot.
    bit [7:0] m_prev;
    bit [7:0] m_pend;
    bit       m_busy;
    int       m_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_prev = '0;
        m_pend = '0;
        m_busy = 1'b0;
        m_cur  = 0;
    endfunction

    function automatic void model_step(input logic [7:0] r, input logic e, input logic a,
                                       input logic [7:0] mk);
        bit [7:0] nxt;
        bit       o;
        bit       xfer;
        bit       found;
        exp_t     x;
        xfer = m_busy && a;
        o    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit rose;
            bit cleared;
            rose    = r[i] && !m_prev[i];
            cleared = xfer && (m_cur == i);
            if (rose && m_pend[i] && !cleared) o = 1'b1;
            if (rose) nxt[i] = 1'b1;
            else if (cleared) nxt[i] = 1'b0;
            else nxt[i] = m_pend[i];
        end
        if (m_busy) begin
            if (a) m_busy = 1'b0;
        end else if (e) begin
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
`ifdef ENC_MASK_EN
                if (!found && m_pend[i] && !mk[i]) begin
`else
                if (!found && m_pend[i]) begin
`endif
                    found  = 1'b1;
                    m_busy = 1'b1;
                    m_cur  = i;
                end
            end
        end
        m_pend = nxt;
        m_prev = r;
        x.v = m_busy;
        x.i = 3'(m_cur);
        x.p = m_pend;
        x.o = o;
        q.push_back(x);
    endfunction

    // Monitor: every expectation pushed at a posedge is checked at the following negedge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("sb_valid", 32'(valid), 32'(mon_e.v));
            if (mon_e.v) chk("sb_idx", 32'(idx), 32'(mon_e.i));
            chk("sb_pending", 32'(pending), 32'(mon_e.p));
            chk("sb_ovf", 32'(ovf), 32'(mon_e.o));
        end
    end

    task automatic cycle(input logic [7:0] r, input logic e, input logic a);
        req = r;
        en  = e;
        ack = a;
        @(posedge clk);
        model_step(r, e, a, mask_r);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        req    = '0;
        ack    = 1'b0;
        mask_r = '0;
        model_reset();
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Single pulse on line 5.
        cycle(8'h00, 1'b1, 1'b0);
        cycle(8'h20, 1'b1, 1'b0);
        chk("p5_pending", 32'(pending), 32'h20);
        chk("p5_valid_early", 32'(valid), 32'd0);
        cycle(8'h00, 1'b1, 1'b0);
        chk("p5_valid", 32'(valid), 32'd1);
        chk("p5_idx", 32'(idx), 32'd5);
        cycle(8'h00, 1'b1, 1'b1);
        chk("p5_ack_pending", 32'(pending), 32'h00);
        chk("p5_ack_valid", 32'(valid), 32'd0);

        // Three lines rising together are presented lowest first, with a bubble between.
        cycle(8'h92, 1'b1, 1'b0);
        cycle(8'h92, 1'b1, 1'b0);
        chk("multi_idx0", 32'(idx), 32'd1);
        cycle(8'h92, 1'b1, 1'b1);
        chk("multi_bubble0", 32'(valid), 32'd0);
        cycle(8'h92, 1'b1, 1'b0);
        chk("multi_idx1", 32'(idx), 32'd4);
        cycle(8'h92, 1'b1, 1'b1);
        chk("multi_bubble1", 32'(valid), 32'd0);
        cycle(8'h92, 1'b1, 1'b0);
        chk("multi_idx2", 32'(idx), 32'd7);
        cycle(8'h92, 1'b1, 1'b1);
        chk("multi_done", 32'(pending), 32'h00);
        cycle(8'h00, 1'b1, 1'b0);

        // Enable low holds off presentation but not capture.
        cycle(8'h08, 1'b0, 1'b0);
        chk("en_pending", 32'(pending), 32'h08);
        cycle(8'h08, 1'b0, 1'b0);
        chk("en_hold_valid", 32'(valid), 32'd0);
        cycle(8'h08, 1'b1, 1'b0);
        chk("en_valid", 32'(valid), 32'd1);
        chk("en_idx", 32'(idx), 32'd3);
        cycle(8'h00, 1'b1, 1'b1);

        // Overflow on a pending line, then a rise coincident with its own ack.
        cycle(8'h04, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h04, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(ovf), 32'd1);
        chk("ovf_pending", 32'(pending), 32'h04);
        cycle(8'h00, 1'b1, 1'b0);
        chk("ovf_one_cycle", 32'(ovf), 32'd0);
        chk("coinc_present", 32'(idx), 32'd2);
        cycle(8'h04, 1'b1, 1'b1);
        chk("coinc_pending", 32'(pending), 32'h04);
        chk("coinc_ovf", 32'(ovf), 32'd0);
        cycle(8'h04, 1'b1, 1'b0);
        chk("coinc_repres", 32'(idx), 32'd2);
        cycle(8'h04, 1'b1, 1'b1);

`ifdef ENC_MASK_EN
        // Masked line 0 stays pending until unmasked.
        cycle(8'h00, 1'b1, 1'b0);
        mask_r = 8'h01;
        cycle(8'h03, 1'b1, 1'b0);
        cycle(8'h03, 1'b1, 1'b0);
        chk("mask_idx", 32'(idx), 32'd1);
        cycle(8'h03, 1'b1, 1'b1);
        chk("mask_left", 32'(pending), 32'h01);
        mask_r = 8'h00;
        cycle(8'h03, 1'b1, 1'b0);
        chk("unmask_idx", 32'(idx), 32'd0);
        cycle(8'h03, 1'b1, 1'b1);
`endif

        // Reset in the middle of presenting line 6.
        cycle(8'h40, 1'b1, 1'b0);
        cycle(8'h40, 1'b1, 1'b0);
        chk("pre_rst_idx", 32'(idx), 32'd6);
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_idx", 32'(idx), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        #1;
        req = 8'h10;
        rst = 1'b0;
        cycle(8'h10, 1'b1, 1'b0);
        cycle(8'h10, 1'b1, 1'b0);
        chk("post_rst_valid", 32'(valid), 32'd1);
        chk("post_rst_idx", 32'(idx), 32'd4);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : req;
`ifdef ENC_MASK_EN
            if ($urandom_range(0, 7) == 0) mask_r = 8'($urandom);
`endif
            cycle(r, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
        end
        mask_r = '0;
        for (int n = 0; n < 20; n++) cycle(8'h00, 1'b1, 1'b1);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_encoder_8to3.md
# irq_encoder_8to3

Registered 8-to-3 priority event encoder. It is the inverse of the team's 3-to-8 decoder. It captures rising edges on eight request lines into a pending register and presents the highest-priority pending index as a 3-bit code with a valid/ack handshake. It sits between raw event sources and a consumer that decodes the index back to a one-hot line.

## Interface
Parameters:
- N_REQ, 8: number of request lines; fixed at 8 for this revision.
- IDX_W, 3: index width, equal to clog2(N_REQ).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enable; gates new presentations only.
- req  in  8  level request lines; bit 0 has the highest priority.
- ack  in  1  consumer accepts the presented index.
- mask  in  8  per-line eligibility mask; 1 = ineligible. Present only with ENC_MASK_EN.
- valid  out  1  idx holds a pending event.
- idx  out  3  encoded index of the presented line.
- pending  out  8  captured, not-yet-acknowledged events.
- ovf  out  1  one-cycle pulse: a rising edge arrived on a line already pending.

## Operation
- Edge capture:
  - req_q <= req every cycle.
  - rise = req & ~req_q.
  - pending <= (pending & ~clr) | rise.
- clr is one-hot at idx when valid && ack, else 0.
- Set wins over clear: a rise on line i in the same cycle that ack clears line i leaves pending[i] = 1 and does not pulse ovf.
- ovf = 1 for one cycle when (rise & pending & ~clr) != 0.
- Eligible vector: elig = pending & ~mask with ENC_MASK_EN, otherwise elig = pending.
- Priority: the lowest set bit of elig wins. Code 000 = line 0 and code 111 = line 7, matching the decoder's D0..D7 order.
- FSM states:
  - IDLE: valid = 0. If en && elig != 0: latch idx = the lowest set bit of elig, go to PRESENT.
  - PRESENT: valid = 1; idx is held stable regardless of new higher-priority events, en, or mask. On ack: clear pending[idx], go to IDLE.
- ack while in IDLE is ignored and has no effect.
- en = 0 blocks the IDLE→PRESENT transition only. Capture continues, and a PRESENT handshake in progress still completes.
- Reset values:
  - state = IDLE
  - valid = 0, idx = 000
  - pending = 00000000, req_q = 00000000
  - ovf = 0
- A line held high at reset release is captured as a rising edge on the first clock after release.
- Reset mid-handshake drops valid immediately (asynchronously) and discards all pending events.

## Timing
- Capture latency: req first sampled high at edge k sets pending after edge k; valid asserts after edge k+1, i.e. 2 cycles from req to valid.
- Handshake: a transfer occurs on a rising edge with valid && ack both high. valid deasserts after that edge and is low for at least one cycle (the IDLE bubble) before the next index is presented.
- Throughput: one index per 2 cycles at best.
- ovf coincides with the edge that would have set the already-set bit.
- All outputs are registered; no combinational path from req, ack, or mask to any output.

## Configuration
- ENC_MASK_EN defined: the mask port exists. Masked lines still capture into pending and can raise ovf, but are never presented. Unmasking a pending line makes it eligible on the next IDLE evaluation.
- ENC_MASK_EN undefined: no mask port; all pending lines are eligible.

## Structure
- Package enc_pkg holds:
  - N_REQ and IDX_W constants.
  - The state typedef: enum of IDLE and PRESENT.
- Sub-module prio_enc8: purely combinational. Takes an 8-bit vector and returns a 3-bit lowest-set-bit index plus an any flag.
- The top level contains the edge detector, pending register, FSM, and the ovf logic.

## Test plan
- Reset, then a single req[5] pulse → pending = 00100000 one cycle later; valid = 1 with idx = 101 two cycles after req; ack → pending = 0, valid = 0.
- req = 10010010 rising together → presented in order idx 001, 100, 111; one presentation per handshake with a one-cycle bubble between each.
- en = 0 while req[3] rises → pending[3] = 1, valid stays 0. Raise en → valid = 1, idx = 011 on the next cycle.
- With line 2 pending and not presented, a second rising edge on req[2] → ovf pulses for exactly one cycle and pending is unchanged. A rise on req[2] coincident with its own ack → pending[2] stays 1 and ovf = 0.
- ENC_MASK_EN with mask = 00000001 and req = 00000011 rising → idx = 001 presented, line 0 stays pending. Clear the mask → idx = 000 presented next.
- Assert rst while valid = 1, idx = 110 → valid, idx, pending, and ovf all read 0 immediately. Release with req[4] high → idx = 100 presented 2 cycles later.
